// File: rtl/keypad_lock_ctrl.sv
// Keypad password controller: one-hot key decode, entry register, runtime password,
// failed-attempt counting with timed lockout, and a buzzer pattern generator.
`timescale 1ns/1ps
module keypad_lock_ctrl #(
    parameter int                  DIGITS     = 3,
    parameter int                  MAX_TRIES  = 6,
    parameter logic [4*DIGITS-1:0] DEFAULT_PW = 12'h246,
    parameter int                  TONE_HALF  = 50000,
    parameter int                  KEY_CYC    = 10000000,
    parameter int                  OK_CYC     = 30000000,
    parameter int                  FAIL_SEG   = 5000000,
    parameter int                  LOCK_CYC   = 500000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [15:0]                   key_onehot,
    output logic [4*DIGITS-1:0]           digits,
    output logic [$clog2(DIGITS+1)-1:0]   count,
    output logic [3:0]                    tries,
    output logic                          unlocked,
    output logic                          locked_out,
    output logic                          buzzer
);

    localparam int W         = 4 * DIGITS;
    localparam int CW        = $clog2(DIGITS + 1);
    localparam int OK_HALF   = (TONE_HALF / 2 < 1) ? 1 : TONE_HALF / 2;
    localparam int FAIL_HALF = 2 * TONE_HALF;
    localparam int FAIL_END  = 3 * FAIL_SEG;
    localparam int PAT_MAX   = (KEY_CYC > OK_CYC)
                             ? ((KEY_CYC > FAIL_END) ? KEY_CYC : FAIL_END)
                             : ((OK_CYC > FAIL_END) ? OK_CYC : FAIL_END);
    localparam int EW        = $clog2(PAT_MAX + 1);
    localparam int PW        = $clog2(FAIL_HALF + 1);
    localparam int LW        = $clog2(LOCK_CYC + 1);

    typedef enum logic [1:0] {S_ENTRY, S_UNLOCKED, S_SET, S_LOCKED} state_t;
    typedef enum logic [1:0] {B_IDLE, B_KEY, B_OK, B_FAIL} bmode_t;
    typedef enum logic [2:0] {K_NONE, K_DIGIT, K_ENTER, K_CLEAR, K_SET, K_MASTER} kind_t;

    state_t          state, state_nxt;
    bmode_t          bmode, ev;
    kind_t           kind;
    logic [3:0]      dval;
    logic [15:0]     k_q, k_prev;
    logic [W-1:0]    ent, pw;
    logic [W+3:0]    ent_cat;
    logic [CW-1:0]   cnt;
    logic [3:0]      tries_q, tries_p1;
    logic [LW-1:0]   lock_tmr;
    logic [EW-1:0]   el;
    logic [PW-1:0]   ph;
    logic            buzz_q;
    logic            full, match;
    logic            ent_clr, ent_shift, tries_inc, tries_clr, pw_load, lock_load;

    function automatic logic [3:0] sat_inc(input logic [3:0] t);
        return (t >= 4'(MAX_TRIES)) ? 4'(MAX_TRIES) : t + 4'd1;
    endfunction

    assign full     = (cnt == CW'(DIGITS));
    assign match    = (ent == pw);
    assign tries_p1 = sat_inc(tries_q);
    assign ent_cat  = {ent, dval};

    // A press is a mapped code appearing after an all-released cycle.
    always_comb begin
        kind = K_NONE;
        dval = 4'd0;
        case (k_q)
            16'h0008: begin kind = K_DIGIT; dval = 4'd0; end
            16'h0080: begin kind = K_DIGIT; dval = 4'd1; end
            16'h0040: begin kind = K_DIGIT; dval = 4'd2; end
            16'h0020: begin kind = K_DIGIT; dval = 4'd3; end
            16'h0800: begin kind = K_DIGIT; dval = 4'd4; end
            16'h0400: begin kind = K_DIGIT; dval = 4'd5; end
            16'h0200: begin kind = K_DIGIT; dval = 4'd6; end
            16'h8000: begin kind = K_DIGIT; dval = 4'd7; end
            16'h4000: begin kind = K_DIGIT; dval = 4'd8; end
            16'h2000: begin kind = K_DIGIT; dval = 4'd9; end
            16'h0001: kind = K_ENTER;
            16'h1000: kind = K_CLEAR;
            16'h0002: kind = K_SET;
            16'h0100: kind = K_MASTER;
            default:  kind = K_NONE;
        endcase
        if (k_prev != 16'd0)
            kind = K_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_ENTRY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ent_clr   = 1'b0;
        ent_shift = 1'b0;
        tries_inc = 1'b0;
        tries_clr = 1'b0;
        pw_load   = 1'b0;
        lock_load = 1'b0;
        ev        = B_IDLE;
        if (kind == K_MASTER) begin
            state_nxt = S_ENTRY;
            ent_clr   = 1'b1;
            tries_clr = 1'b1;
            ev        = B_KEY;
        end else begin
            case (state)
                S_ENTRY, S_SET: begin
                    if (kind == K_DIGIT && !full) begin
                        ent_shift = 1'b1;
                        ev        = B_KEY;
                    end else if (kind == K_ENTER && full) begin
                        ent_clr = 1'b1;
                        if (state == S_SET) begin
                            pw_load   = 1'b1;
                            state_nxt = S_ENTRY;
                            ev        = B_OK;
                        end else if (match) begin
                            state_nxt = S_UNLOCKED;
                            tries_clr = 1'b1;
                            ev        = B_OK;
                        end else begin
                            tries_inc = 1'b1;
                            ev        = B_FAIL;
                            if (tries_p1 == 4'(MAX_TRIES)) begin
                                state_nxt = S_LOCKED;
                                lock_load = 1'b1;
                            end
                        end
                    end else if (kind == K_CLEAR) begin
                        ent_clr = 1'b1;
                        if (state == S_SET)
                            state_nxt = S_UNLOCKED;
                        else
                            ev = B_KEY;
                    end
                end
                S_UNLOCKED: begin
                    if (kind == K_CLEAR) begin
                        state_nxt = S_ENTRY;
                        ent_clr   = 1'b1;
                    end else if (kind == K_SET) begin
                        state_nxt = S_SET;
                        ent_clr   = 1'b1;
                        ev        = B_KEY;
                    end
                end
                S_LOCKED: begin
                    if (lock_tmr == '0) begin
                        state_nxt = S_ENTRY;
                        tries_clr = 1'b1;
                        ent_clr   = 1'b1;
                    end
                end
                default: state_nxt = S_ENTRY;
            endcase
        end
    end

    always_comb begin
        unlocked   = (state == S_UNLOCKED) || (state == S_SET);
        locked_out = (state == S_LOCKED);
        count      = cnt;
        tries      = tries_q;
        buzzer     = buzz_q;
        case (state)
            S_UNLOCKED: digits = {DIGITS{4'hA}};
            S_LOCKED:   digits = '0;
            default:    digits = ent;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= '0;
            k_prev   <= '0;
            ent      <= '1;
            cnt      <= '0;
            tries_q  <= '0;
            pw       <= DEFAULT_PW;
            lock_tmr <= '0;
        end else begin
            k_q    <= key_onehot;
            k_prev <= k_q;
            if (ent_clr) begin
                ent <= '1;
                cnt <= '0;
            end else if (ent_shift) begin
                ent <= ent_cat[W-1:0];
                cnt <= cnt + CW'(1);
            end
            if (tries_clr)
                tries_q <= '0;
            else if (tries_inc)
                tries_q <= tries_p1;
            if (pw_load)
                pw <= ent;
            // Timer reads 0 on the final locked cycle; leaving LOCKED parks it at 0.
            if (lock_load)
                lock_tmr <= LW'(LOCK_CYC - 1);
            else if (state == S_LOCKED && state_nxt == S_LOCKED)
                lock_tmr <= lock_tmr - LW'(1);
            else
                lock_tmr <= '0;
        end
    end

    // Pattern generator: el counts cycles since the event, ph counts within a half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            bmode  <= B_IDLE;
            el     <= '0;
            ph     <= '0;
            buzz_q <= 1'b0;
        end else if (ev != B_IDLE) begin
            bmode  <= ev;
            el     <= '0;
            ph     <= '0;
            buzz_q <= 1'b1;
        end else begin
            case (bmode)
                B_KEY, B_OK: begin
                    if (el == ((bmode == B_KEY) ? EW'(KEY_CYC - 1) : EW'(OK_CYC - 1))) begin
                        bmode  <= B_IDLE;
                        el     <= '0;
                        ph     <= '0;
                        buzz_q <= 1'b0;
                    end else begin
                        el <= el + EW'(1);
                        if (ph == ((bmode == B_KEY) ? PW'(TONE_HALF - 1) : PW'(OK_HALF - 1))) begin
                            ph     <= '0;
                            buzz_q <= ~buzz_q;
                        end else begin
                            ph <= ph + PW'(1);
                        end
                    end
                end
                B_FAIL: begin
                    if (el == EW'(FAIL_END - 1)) begin
                        bmode  <= B_IDLE;
                        el     <= '0;
                        ph     <= '0;
                        buzz_q <= 1'b0;
                    end else begin
                        el <= el + EW'(1);
                        if (el == EW'(FAIL_SEG - 1)) begin
                            ph     <= '0;
                            buzz_q <= 1'b0;
                        end else if (el == EW'(2 * FAIL_SEG - 1)) begin
                            ph     <= '0;
                            buzz_q <= 1'b1;
                        end else if (el < EW'(FAIL_SEG - 1) || el >= EW'(2 * FAIL_SEG)) begin
                            if (ph == PW'(FAIL_HALF - 1)) begin
                                ph     <= '0;
                                buzz_q <= ~buzz_q;
                            end else begin
                                ph <= ph + PW'(1);
                            end
                        end
                    end
                end
                default: begin
                    el     <= '0;
                    ph     <= '0;
                    buzz_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with short timing parameters and a snapshot scoreboard.
`timescale 1ns/1ps
module tb_keypad_lock_ctrl;

    localparam int TH = 2, KC = 12, OC = 16, FS = 20, LC = 50;
    localparam logic [15:0] K1 = 16'h0080, K2 = 16'h0040, K4 = 16'h0800, K5 = 16'h0400,
                            K6 = 16'h0200, K7 = 16'h8000, K8 = 16'h4000, K9 = 16'h2000,
                            KENT = 16'h0001, KCLR = 16'h1000, KSET = 16'h0002, KMST = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] key_onehot = 16'd0;
    logic [11:0] digits;
    logic [1:0]  count;
    logic [3:0]  tries;
    logic        unlocked, locked_out, buzzer;

    typedef struct packed {
        logic [11:0] dg;
        logic [1:0]  cnt;
        logic [3:0]  tr;
        logic        ul;
        logic        lo;
    } snap_t;

    snap_t sb[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    keypad_lock_ctrl #(
        .DIGITS(3), .MAX_TRIES(2), .DEFAULT_PW(12'h246), .TONE_HALF(TH),
        .KEY_CYC(KC), .OK_CYC(OC), .FAIL_SEG(FS), .LOCK_CYC(LC)
    ) dut (
        .clk(clk), .rst(rst), .key_onehot(key_onehot), .digits(digits), .count(count),
        .tries(tries), .unlocked(unlocked), .locked_out(locked_out), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    function automatic snap_t mk(input logic [11:0] dg, input logic [1:0] c, input logic [3:0] t,
                                 input logic ul, input logic lo);
        return '{dg: dg, cnt: c, tr: t, ul: ul, lo: lo};
    endfunction

    // kind: 0 idle, 1 key beep, 2 OK tone, 3 fail pattern; c = cycles since the event
    function automatic logic model_buzz(input int kind, input int c);
        case (kind)
            1:       return (c < KC) && ((c / TH) % 2 == 0);
            2:       return (c < OC) && ((c / (TH / 2)) % 2 == 0);
            3: begin
                if (c < FS)     return ((c / (2 * TH)) % 2 == 0);
                if (c < 2 * FS) return 1'b0;
                if (c < 3 * FS) return (((c - 2 * FS) / (2 * TH)) % 2 == 0);
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [15:0] code);
        key_onehot = code;
        tick();
        key_onehot = 16'd0;
        tick();
    endtask

    task automatic check_snap(input string tag);
        snap_t e, o;
        o = {digits, count, tries, unlocked, locked_out};
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (dg,cnt,tr,ul,lo)", tag, o, e);
        end
    endtask

    task automatic step(input logic [15:0] code, input snap_t e, input string tag);
        sb.push_back(e);
        press(code);
        check_snap(tag);
    endtask

    task automatic check_buzz(input int kind, input int n, input string tag);
        logic [63:0] obs, exp;
        obs = '0;
        exp = '0;
        for (int c = 0; c < n; c++) begin
            obs[c] = buzzer;
            exp[c] = model_buzz(kind, c);
            if (c < n - 1) tick();
        end
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        sb.push_back(mk(12'hFFF, 0, 0, 0, 0));
        check_snap("reset");
        n_assert++;
        assert (buzzer === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_buzzer: observed %b expected 0", buzzer);
        end

        step(K2, mk(12'hFF2, 1, 0, 0, 0), "digit2");
        check_buzz(1, 16, "key_beep");
        step(K4, mk(12'hF24, 2, 0, 0, 0), "digit4");
        step(K6, mk(12'h246, 3, 0, 0, 0), "digit6");
        step(KENT, mk(12'hAAA, 0, 0, 1, 0), "unlock_default");
        check_buzz(2, 20, "ok_tone");
        step(KCLR, mk(12'hFFF, 0, 0, 0, 0), "clear_from_unlocked");

        // Held key: exactly one beep, then silence while still held.
        sb.push_back(mk(12'hFF5, 1, 0, 0, 0));
        key_onehot = K5;
        tick();
        tick();
        check_buzz(1, 64, "held_key_one_beep");
        repeat (40) tick();
        key_onehot = 16'd0;
        tick();
        tick();
        check_snap("held_key5");
        step(KENT, mk(12'hFF5, 1, 0, 0, 0), "enter_short");
        check_buzz(0, 4, "enter_short_quiet");
        step(16'h0003, mk(12'hFF5, 1, 0, 0, 0), "multi_hot_ignored");
        step(16'h0010, mk(12'hFF5, 1, 0, 0, 0), "unmapped_ignored");

        step(KCLR, mk(12'hFFF, 0, 0, 0, 0), "clear_entry");
        step(K1, mk(12'hFF1, 1, 0, 0, 0), "a1");
        step(K1, mk(12'hF11, 2, 0, 0, 0), "a11");
        step(K1, mk(12'h111, 3, 0, 0, 0), "a111");
        repeat (20) tick();
        step(K2, mk(12'h111, 3, 0, 0, 0), "full_digit_ignored");
        check_buzz(0, 8, "full_digit_no_beep");
        step(KENT, mk(12'hFFF, 0, 1, 0, 0), "fail1");
        check_buzz(3, 64, "fail_pattern");

        step(K1, mk(12'hFF1, 1, 1, 0, 0), "b1");
        step(K1, mk(12'hF11, 2, 1, 0, 0), "b11");
        step(K1, mk(12'h111, 3, 1, 0, 0), "b111");
        step(KENT, mk(12'h000, 0, 2, 0, 1), "lock_enter");
        step(K1, mk(12'h000, 0, 2, 0, 1), "lock_digit_ignored");
        n = 2;
        while (locked_out === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        n_assert++;
        assert (n == LC) else begin
            n_fail++;
            $error("FAIL lock_length: observed %0d expected %0d", n, LC);
        end
        sb.push_back(mk(12'hFFF, 0, 0, 0, 0));
        check_snap("lock_exit");

        step(K2, mk(12'hFF2, 1, 0, 0, 0), "c2");
        step(K4, mk(12'hF24, 2, 0, 0, 0), "c4");
        step(K6, mk(12'h246, 3, 0, 0, 0), "c6");
        step(KENT, mk(12'hAAA, 0, 0, 1, 0), "unlock2");
        step(K5, mk(12'hAAA, 0, 0, 1, 0), "unlocked_digit_ignored");
        step(KSET, mk(12'hFFF, 0, 0, 1, 0), "set_entry");
        step(K7, mk(12'hFF7, 1, 0, 1, 0), "s7");
        step(K8, mk(12'hF78, 2, 0, 1, 0), "s8");
        step(K9, mk(12'h789, 3, 0, 1, 0), "s9");
        step(KENT, mk(12'hFFF, 0, 0, 0, 0), "pw_saved");
        check_buzz(2, 20, "pw_saved_ok_tone");
        step(K2, mk(12'hFF2, 1, 0, 0, 0), "o2");
        step(K4, mk(12'hF24, 2, 0, 0, 0), "o4");
        step(K6, mk(12'h246, 3, 0, 0, 0), "o6");
        step(KENT, mk(12'hFFF, 0, 1, 0, 0), "old_pw_fails");
        step(K7, mk(12'hFF7, 1, 1, 0, 0), "n7");
        step(K8, mk(12'hF78, 2, 1, 0, 0), "n8");
        step(K9, mk(12'h789, 3, 1, 0, 0), "n9");
        step(KENT, mk(12'hAAA, 0, 0, 1, 0), "new_pw_unlocks");

        step(KCLR, mk(12'hFFF, 0, 0, 0, 0), "relock_clear");
        for (int a = 1; a <= 2; a++) begin
            press(K1);
            press(K1);
            press(K1);
            step(KENT, (a == 2) ? mk(12'h000, 0, 2, 0, 1) : mk(12'hFFF, 0, 1, 0, 0), "relock_fail");
        end
        repeat (5) tick();
        step(KMST, mk(12'hFFF, 0, 0, 0, 0), "master_in_lock");
        check_buzz(1, 16, "master_beep");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.push_back(mk(12'hFFF, 0, 0, 0, 0));
        check_snap("reset_mid_run");
        press(K7);
        press(K8);
        press(K9);
        step(KENT, mk(12'hFFF, 0, 1, 0, 0), "runtime_pw_lost");
        press(K2);
        press(K4);
        press(K6);
        step(KENT, mk(12'hAAA, 0, 0, 1, 0), "default_pw_back");
        step(KSET, mk(12'hFFF, 0, 0, 1, 0), "set_again");
        step(KCLR, mk(12'hAAA, 0, 0, 1, 0), "set_cancel");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_lock_ctrl.md
# keypad_lock_ctrl

Parametrised keypad password controller for the 4x4 one-hot keypad path. It decodes key presses into a DIGITS-long entry register and compares that entry against a password that can be reprogrammed at runtime. It counts failed attempts, enforces a timed lockout after MAX_TRIES failures, and drives a buzzer with distinct key, success and fail patterns. It sits between the keypad scanner (one-hot output) and the seven-segment display driver (packed hex nibbles).

## Interface
- DIGITS, 3: password/entry length in decimal digits (1..8).
- MAX_TRIES, 6: consecutive failures that trigger lockout (1..15).
- DEFAULT_PW, 12'h246: reset password, 4*DIGITS bits, one BCD nibble per digit, MSD first.
- TONE_HALF, 50000: buzzer half-period in clk cycles for the key tone.
- KEY_CYC, 10000000: key-beep duration in cycles.
- OK_CYC, 30000000: success-tone duration in cycles.
- FAIL_SEG, 5000000: fail-pattern segment length in cycles.
- LOCK_CYC, 500000000: lockout duration in cycles.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- key_onehot  in  16  keypad level, held while pressed; 0 = no key.
- digits  out  4*DIGITS  display nibbles; [3:0] is the most recent digit.
- count  out  $clog2(DIGITS+1)  digits entered so far.
- tries  out  4  consecutive failed attempts.
- unlocked  out  1  high in UNLOCKED and SET_ENTRY.
- locked_out  out  1  high in LOCKED.
- buzzer  out  1  square-wave buzzer drive.

## Operation
- Key map: 0x0008=0, 0x0080=1, 0x0040=2, 0x0020=3, 0x0800=4, 0x0400=5, 0x0200=6, 0x8000=7, 0x4000=8, 0x2000=9.
- Control keys: 0x0001=ENTER, 0x1000=CLEAR, 0x0002=SET, 0x0100=MASTER. All other codes, including multi-hot codes, are ignored.
- Press = key_onehot registered into k_q. A press is valid when k_q is a mapped code and the previous k_q was 0. A held key yields exactly one press.
- Digit press while count<DIGITS: digits <= {digits[4*DIGITS-5:0], d}, count+1, key beep. Digit press while count==DIGITS is ignored, with no beep.
- Empty positions show 4'hF. UNLOCKED shows all 4'hA. LOCKED shows all 4'h0.
- State ENTRY:
  - ENTER with count<DIGITS: ignored.
  - ENTER with count==DIGITS and digits==pw: go to UNLOCKED, tries<=0, OK tone.
  - ENTER with a mismatch: tries+1, entry cleared, fail tone. If the new tries==MAX_TRIES, go to LOCKED and load the lock timer.
  - CLEAR: entry cleared, key beep.
- State UNLOCKED:
  - CLEAR: go to ENTRY with a blank entry.
  - SET: go to SET_ENTRY with a blank entry, key beep.
  - Digits and ENTER: ignored.
- State SET_ENTRY:
  - Digits enter as in ENTRY.
  - ENTER with count==DIGITS: pw<=digits, OK tone, go to ENTRY with a blank entry.
  - CLEAR: go back to UNLOCKED; pw is unchanged.
- State LOCKED:
  - All keys except MASTER are ignored.
  - When the timer reaches 0: go to ENTRY, tries<=0.
- MASTER in any state: go to ENTRY, blank entry, tries<=0, key beep. pw is kept.
- Buzzer: each event restarts the pattern generator. The newest event wins, and result tones replace a running key beep.
  - Key beep: toggles every TONE_HALF cycles for KEY_CYC cycles.
  - OK tone: toggles every TONE_HALF/2 cycles for OK_CYC cycles.
  - Fail tone: toggles every 2*TONE_HALF cycles during [0,FAIL_SEG) and [2*FAIL_SEG,3*FAIL_SEG), and is held 0 otherwise.
  - When idle, buzzer=0.

## Timing
- Reset values:
  - state=ENTRY, pw=DEFAULT_PW.
  - digits all 4'hF, count=0, tries=0.
  - unlocked=0, locked_out=0, buzzer=0.
  - k_q=0, all timers 0.
- Latency: key_onehot changing at edge N is captured in k_q at N. The state, digits, count, tries, flags and the first buzzer=1 all update at edge N+1.
- Buzzer is 1 on the first event cycle. Its first toggle comes TONE_HALF cycles later (TONE_HALF/2 for OK, 2*TONE_HALF for fail).
- Lock timer is loaded with LOCK_CYC-1 on the edge that enters LOCKED and decrements every cycle. The exit to ENTRY occurs on the edge after it reads 0, so locked_out is high for exactly LOCK_CYC cycles.
- MASTER pressed in the cycle the timer expires: result is ENTRY, tries=0, key beep.
- rst asserted mid-pattern or mid-lockout: all state returns to reset values on that edge. A password set at runtime is lost.
- All counters are sized to their parameters and never wrap. tries saturates at MAX_TRIES.

## Test plan
- Reset, then press 2,4,6,ENTER (DEFAULT_PW=12'h246) -> digits=12'h246 after the third digit, then unlocked=1, digits=12'hAAA, tries=0, buzzer toggling at TONE_HALF/2.
- Hold key 5 for 100 cycles, then press ENTER with count=1 -> digits=12'hFF5, count=1, exactly one key beep; ENTER causes no state change.
- With MAX_TRIES=2 and LOCK_CYC=50, enter 111 ENTER twice -> tries=1 then 2. locked_out=1 with digits=12'h000 for exactly 50 cycles, then ENTRY with tries=0. Digit presses during lockout are ignored.
- From UNLOCKED: SET,7,8,9,ENTER, then 2,4,6,ENTER fails (tries=1), then 7,8,9,ENTER -> unlocked=1.
- Assert MASTER during LOCKED -> next cycle locked_out=0, tries=0. Assert rst after a password change -> the password is 12'h246 again.
- Fail tone with FAIL_SEG=20 and TONE_HALF=2 -> buzzer toggles every 4 cycles during cycles 0-19, is 0 during 20-39, toggles during 40-59, then stays 0.
